// File: rtl/float_mul_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: tag format and the
// rotating-priority search used by the round-robin arbiter.
package float_mul_arb_pkg;

    localparam int FLOAT_W = 32;
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // Scan downward so the candidate nearest to ptr+1 is written last and wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [ID_W-1:0]    ptr,
                                      input int                 n);
        pick_t           res;
        logic [ID_W-1:0] pos;
        res = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                pos = ID_W'((int'(ptr) + k) % n);
                if (req[pos]) begin
                    res.found = 1'b1;
                    res.idx   = pos;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/float_mul_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the last grantee,
// pointer moves only on cycles that actually grant.
module rr_arbiter
    import float_mul_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    grant_o,
    output logic            grant_vld_o,
    output logic [ID_W-1:0] grant_idx_o
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
        pick           = rr_pick(req_ext, ptr_q, N);
        grant_o        = '0;
        for (int i = 0; i < N; i++) begin
            grant_o[i] = pick.found && (pick.idx == ID_W'(i));
        end
        ptr_d = pick.found ? pick.idx : ptr_q;
    end

    assign grant_vld_o = pick.found;
    assign grant_idx_o = pick.idx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q <= ID_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/float_mul_arb_shift_reg.sv
// Fixed-depth shift register with asynchronous clear; carries request tags
// in lockstep with the multiplier pipeline.
module shift_reg #(
    parameter int WIDTH = 1,
    parameter int STAGE = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGE];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < STAGE; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGE; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGE-1];

endmodule

// File: rtl/float_mul_arb.sv
// Shares one fixed-latency float multiplier between N_REQ requesters; tags
// ride alongside the multiplier so each result returns to its issuer.
module float_mul_arb #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 16,
    parameter int FLOAT_W = 32
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*FLOAT_W-1:0]     req_din1,
    input  logic [N_REQ*FLOAT_W-1:0]     req_din2,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [FLOAT_W-1:0]           rsp_dout,
    output logic [FLOAT_W-1:0]           mul_din1,
    output logic [FLOAT_W-1:0]           mul_din2,
    output logic                         mul_din_valid,
    input  logic [FLOAT_W-1:0]           mul_dout,
    input  logic                         mul_dout_valid,
    output logic [$clog2(MUL_LAT+2)-1:0] inflight,
    output logic                         sync_err
);

    import float_mul_arb_pkg::*;

    localparam int               CNT_W   = $clog2(MUL_LAT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_LAT + 1);

    logic [N_REQ-1:0]   grant;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;

    logic [FLOAT_W-1:0] din1_q, din1_d;
    logic [FLOAT_W-1:0] din2_q, din2_d;
    logic               din_vld_q, din_vld_d;
    tag_t               iss_tag_q, iss_tag_d;
    tag_t               ret_tag;

    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [FLOAT_W-1:0] rsp_dout_q, rsp_dout_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               sync_err_q, sync_err_d;

    logic               hit;
    logic               mismatch;
    logic               sat;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk         (clk),
        .nrst        (nrst),
        .req_i       (req_valid),
        .grant_o     (grant),
        .grant_vld_o (grant_vld),
        .grant_idx_o (grant_idx)
    );

    shift_reg #(.WIDTH($bits(tag_t)), .STAGE(MUL_LAT)) u_tag_pipe (
        .clk  (clk),
        .nrst (nrst),
        .d_i  (iss_tag_q),
        .q_o  (ret_tag)
    );

    // Issue stage: operands hold their last value when nothing is accepted.
    always_comb begin
        din1_d = din1_q;
        din2_d = din2_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                din1_d = req_din1[i*FLOAT_W +: FLOAT_W];
                din2_d = req_din2[i*FLOAT_W +: FLOAT_W];
            end
        end
        din_vld_d       = grant_vld;
        iss_tag_d.valid = grant_vld;
        iss_tag_d.id    = grant_idx;
    end

    // Return stage: a result is only delivered when data and tag agree.
    always_comb begin
        hit        = mul_dout_valid & ret_tag.valid;
        mismatch   = mul_dout_valid ^ ret_tag.valid;
        rsp_dout_d = hit ? mul_dout : rsp_dout_q;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = hit && (ret_tag.id == ID_W'(i));
        end

        sat        = 1'b0;
        inflight_d = inflight_q;
        if (grant_vld && !hit) begin
            if (inflight_q == CNT_MAX) sat = 1'b1;
            else                       inflight_d = inflight_q + 1'b1;
        end else if (!grant_vld && hit) begin
            if (inflight_q == '0) sat = 1'b1;
            else                  inflight_d = inflight_q - 1'b1;
        end
        sync_err_d = sync_err_q | mismatch | sat;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            din1_q      <= '0;
            din2_q      <= '0;
            din_vld_q   <= 1'b0;
            iss_tag_q   <= '0;
            rsp_valid_q <= '0;
            rsp_dout_q  <= '0;
            inflight_q  <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            din1_q      <= din1_d;
            din2_q      <= din2_d;
            din_vld_q   <= din_vld_d;
            iss_tag_q   <= iss_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dout_q  <= rsp_dout_d;
            inflight_q  <= inflight_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign req_ready     = grant;
    assign mul_din1      = din1_q;
    assign mul_din2      = din2_q;
    assign mul_din_valid = din_vld_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_dout      = rsp_dout_q;
    assign inflight      = inflight_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_float_mul_arb.sv
// Directed bench for float_mul_arb with a behavioural fixed-latency multiplier
// whose latency can be stretched by one cycle to provoke misalignment.
module tb_float_mul_arb;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 16;
    localparam int FW      = 32;
    localparam int CW      = $clog2(MUL_LAT + 2);

    logic                  clk;
    logic                  nrst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*FW-1:0]   req_din1;
    logic [N_REQ*FW-1:0]   req_din2;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      rsp_valid;
    logic [FW-1:0]         rsp_dout;
    logic [FW-1:0]         mul_din1;
    logic [FW-1:0]         mul_din2;
    logic                  mul_din_valid;
    logic [FW-1:0]         mul_dout;
    logic                  mul_dout_valid;
    logic [CW-1:0]         inflight;
    logic                  sync_err;

    float_mul_arb #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .FLOAT_W(FW)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .req_valid      (req_valid),
        .req_din1       (req_din1),
        .req_din2       (req_din2),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_dout       (rsp_dout),
        .mul_din1       (mul_din1),
        .mul_din2       (mul_din2),
        .mul_din_valid  (mul_din_valid),
        .mul_dout       (mul_dout),
        .mul_dout_valid (mul_dout_valid),
        .inflight       (inflight),
        .sync_err       (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact-product float multiply for normal operands (truncating).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] m;
        logic [22:0] f;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 1;
        end else begin
            f = m[45:23];
        end
        return {s, e[7:0], f};
    endfunction

    logic        model_extra = 1'b0;
    logic        pv [0:MUL_LAT] = '{default: 1'b0};
    logic [31:0] pd [0:MUL_LAT] = '{default: 32'd0};

    always @(posedge clk) begin
        pv[0] <= mul_din_valid;
        pd[0] <= fmul(mul_din1, mul_din2);
        for (int k = 1; k <= MUL_LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end

    assign mul_dout_valid = model_extra ? pv[MUL_LAT] : pv[MUL_LAT-1];
    assign mul_dout       = model_extra ? pd[MUL_LAT] : pd[MUL_LAT-1];

    int          g_idx [$];
    int          g_cyc [$];
    int          r_idx [$];
    int          r_cyc [$];
    logic [31:0] r_dat [$];
    int          iss_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                g_idx.push_back(i);
                g_cyc.push_back(cyc);
            end
            if (rsp_valid[i]) begin
                r_idx.push_back(i);
                r_dat.push_back(rsp_dout);
                r_cyc.push_back(cyc);
            end
        end
        if (mul_din_valid) iss_cnt <= iss_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input int base, input int n, input int limit);
        for (int k = 0; k < limit && r_idx.size() < base + n; k++) tick();
        if (r_idx.size() < base + n) chk({tag, "_timeout"}, r_idx.size(), base + n);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_din1[i*FW +: FW] = a;
        req_din2[i*FW +: FW] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] golden [N_REQ];
    int t0, gb, rb, ib;

    initial begin
        golden[0] = 32'h40400000;
        golden[1] = 32'hC1FE0000;
        golden[2] = 32'h41100000;
        golden[3] = 32'h3E800000;
        nrst = 1'b1; req_valid = '0; req_din1 = '0; req_din2 = '0;
        #1 nrst = 1'b0;
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dout", rsp_dout, 0);
        chk("rst_mul_vld", mul_din_valid, 0);
        chk("rst_mul_din1", mul_din1, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_sync_err", sync_err, 0);
        repeat (3) tick();
        nrst = 1'b1;
        tick();

        // Single op
        set_ops(0, 32'h3FC00000, 32'h40000000);
        rb = r_idx.size();
        req_valid = 4'b0001;
        #1 chk("single_ready", req_ready, 4'b0001);
        t0 = cyc;
        tick();
        req_valid = '0;
        #1;
        chk("single_inflight1", inflight, 1);
        chk("single_mul_vld", mul_din_valid, 1);
        chk("single_mul_din1", mul_din1, 32'h3FC00000);
        wait_rsp("single", rb, 1, 30);
        chk("single_rsp_idx", r_idx[rb], 0);
        chk("single_rsp_dat", r_dat[rb], 32'h40400000);
        chk("single_rsp_cyc", r_cyc[rb], t0 + 18);
        chk("single_inflight0", inflight, 0);
        chk("single_sync_err", sync_err, 0);

        // Fairness from a fresh pointer
        nrst = 1'b0; tick(); tick(); nrst = 1'b1; tick();
        set_ops(0, 32'h3FC00000, 32'h40000000);
        set_ops(1, 32'hC2FE0000, 32'h3E800000);
        set_ops(2, 32'h40400000, 32'h40400000);
        set_ops(3, 32'h3F000000, 32'h3F000000);
        gb = g_idx.size(); rb = r_idx.size(); ib = iss_cnt;
        req_valid = 4'b1111;
        repeat (12) tick();
        req_valid = '0;
        tick();
        chk("fair_grants", g_idx.size() - gb, 12);
        chk("fair_issue_cnt", iss_cnt - ib, 12);
        for (int k = 0; k < 12; k++) begin
            chk("fair_grant_idx", g_idx[gb+k], k % 4);
            chk("fair_grant_cyc", g_cyc[gb+k], g_cyc[gb] + k);
        end
        wait_rsp("fair", rb, 12, 40);
        for (int k = 0; k < 12; k++) begin
            chk("fair_rsp_idx", r_idx[rb+k], k % 4);
            chk("fair_rsp_dat", r_dat[rb+k], golden[k%4]);
            chk("fair_rsp_cyc", r_cyc[rb+k], g_cyc[gb+k] + 18);
        end

        // Pointer holds across idle cycles
        gb = g_idx.size(); rb = r_idx.size();
        req_valid = 4'b0100;
        #1 chk("hold_req2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        repeat (5) tick();
        req_valid = 4'b1010;
        #1 chk("hold_first_req3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0010;
        #1 chk("hold_then_req1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("hold_order0", g_idx[gb], 2);
        chk("hold_order1", g_idx[gb+1], 3);
        chk("hold_order2", g_idx[gb+2], 1);
        wait_rsp("hold", rb, 3, 40);

        // Mixed signs and zero
        set_ops(3, 32'h00000000, 32'hBF000000);
        rb = r_idx.size();
        req_valid = 4'b1010;
        #1 chk("mix_first_req3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_rsp("mix", rb, 2, 40);
        chk("mix_rsp0_idx", r_idx[rb], 3);
        chk("mix_rsp0_mag", r_dat[rb][30:0], 0);
        chk("mix_rsp1_idx", r_idx[rb+1], 1);
        chk("mix_rsp1_dat", r_dat[rb+1], 32'hC1FE0000);
        tick();
        chk("mix_inflight0", inflight, 0);
        chk("mix_sync_err", sync_err, 0);

        // Misalignment: multiplier one cycle slower than expected
        model_extra = 1'b1;
        rb = r_idx.size();
        req_valid = 4'b0001;
        #1 t0 = cyc;
        tick();
        req_valid = '0;
        repeat (16) tick();
        chk("mis_pre_err", sync_err, 0);
        tick();
        chk("mis_cyc", cyc, t0 + 18);
        chk("mis_err_set", sync_err, 1);
        repeat (5) tick();
        chk("mis_no_rsp", r_idx.size(), rb);
        chk("mis_err_held", sync_err, 1);
        nrst = 1'b0;
        #1 chk("mis_err_cleared", sync_err, 0);
        tick(); tick();
        nrst = 1'b1;
        model_extra = 1'b0;
        tick();

        // Reset mid-flight
        req_valid = 4'b0001;
        #1 t0 = cyc;
        repeat (5) tick();
        req_valid = '0;
        tick();
        chk("mid_inflight5", inflight, 5);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_mul_vld", mul_din_valid, 0);
        chk("mid_mul_din1", mul_din1, 0);
        chk("mid_mul_din2", mul_din2, 0);
        chk("mid_inflight0", inflight, 0);
        tick(); tick();
        nrst = 1'b1;
        rb = r_idx.size();
        while (cyc < t0 + 24) tick();
        chk("mid_no_rsp", r_idx.size(), rb);
        chk("mid_sync_err", sync_err, 1);
        chk("mid_inflight_end", inflight, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
